// File: rtl/ram_dual_arbiter.sv
// Two-requester front end for a single ram_dual: independent round-robin arbitration of the
// RAM write port and read port, with a registered per-requester read-valid strobe.
module ram_dual_arbiter #(
  parameter int ADDRESS_BITS = 4,
  parameter int DATA_BITS    = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    a_valid,
  input  logic                    a_write,
  input  logic [ADDRESS_BITS-1:0] a_address,
  input  logic [DATA_BITS-1:0]    a_data,
  output logic                    a_ready,
  output logic                    a_rvalid,
  output logic [DATA_BITS-1:0]    a_rdata,
  input  logic                    b_valid,
  input  logic                    b_write,
  input  logic [ADDRESS_BITS-1:0] b_address,
  input  logic [DATA_BITS-1:0]    b_data,
  output logic                    b_ready,
  output logic                    b_rvalid,
  output logic [DATA_BITS-1:0]    b_rdata,
  output logic                    ram_write,
  output logic [ADDRESS_BITS-1:0] ram_address_in,
  output logic [ADDRESS_BITS-1:0] ram_address_out,
  output logic [DATA_BITS-1:0]    ram_data_in,
  input  logic [DATA_BITS-1:0]    ram_data_out
);

  typedef enum logic {LAST_A = 1'b0, LAST_B = 1'b1} last_e;

  last_e wr_last_q, wr_last_d;
  last_e rd_last_q, rd_last_d;
  logic  a_rvalid_q, a_rvalid_d;
  logic  b_rvalid_q, b_rvalid_d;

  logic a_wr_s, b_wr_s, a_rd_s, b_rd_s;
  logic wr_grant_a_s, wr_grant_b_s, rd_grant_a_s, rd_grant_b_s;

  // Arbitration, pointer update and RAM-side muxing; everything is forced idle in reset.
  always_comb begin
    a_wr_s = a_valid &  a_write & reset;
    b_wr_s = b_valid &  b_write & reset;
    a_rd_s = a_valid & ~a_write & reset;
    b_rd_s = b_valid & ~b_write & reset;

    // On a tie the requester not granted most recently wins.
    wr_grant_a_s = a_wr_s & (~b_wr_s | (wr_last_q == LAST_B));
    wr_grant_b_s = b_wr_s & (~a_wr_s | (wr_last_q == LAST_A));
    rd_grant_a_s = a_rd_s & (~b_rd_s | (rd_last_q == LAST_B));
    rd_grant_b_s = b_rd_s & (~a_rd_s | (rd_last_q == LAST_A));

    wr_last_d = wr_last_q;
    if (wr_grant_a_s) begin
      wr_last_d = LAST_A;
    end else if (wr_grant_b_s) begin
      wr_last_d = LAST_B;
    end else begin
      wr_last_d = wr_last_q;
    end

    rd_last_d = rd_last_q;
    if (rd_grant_a_s) begin
      rd_last_d = LAST_A;
    end else if (rd_grant_b_s) begin
      rd_last_d = LAST_B;
    end else begin
      rd_last_d = rd_last_q;
    end

    a_ready = wr_grant_a_s | rd_grant_a_s;
    b_ready = wr_grant_b_s | rd_grant_b_s;

    ram_write      = wr_grant_a_s | wr_grant_b_s;
    ram_address_in = {ADDRESS_BITS{1'b0}};
    ram_data_in    = {DATA_BITS{1'b0}};
    if (wr_grant_a_s) begin
      ram_address_in = a_address;
      ram_data_in    = a_data;
    end else if (wr_grant_b_s) begin
      ram_address_in = b_address;
      ram_data_in    = b_data;
    end else begin
      ram_address_in = {ADDRESS_BITS{1'b0}};
      ram_data_in    = {DATA_BITS{1'b0}};
    end

    ram_address_out = {ADDRESS_BITS{1'b0}};
    if (rd_grant_a_s) begin
      ram_address_out = a_address;
    end else if (rd_grant_b_s) begin
      ram_address_out = b_address;
    end else begin
      ram_address_out = {ADDRESS_BITS{1'b0}};
    end

    a_rvalid_d = rd_grant_a_s;
    b_rvalid_d = rd_grant_b_s;

    // RAM data lands one cycle after the address, aligned with the registered strobe.
    a_rvalid = a_rvalid_q;
    b_rvalid = b_rvalid_q;
    a_rdata  = a_rvalid_q ? ram_data_out : {DATA_BITS{1'b0}};
    b_rdata  = b_rvalid_q ? ram_data_out : {DATA_BITS{1'b0}};
  end

  // Round-robin pointers and read-valid strobes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_last_q  <= LAST_B;
      rd_last_q  <= LAST_B;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      wr_last_q  <= wr_last_d;
      rd_last_q  <= rd_last_d;
      a_rvalid_q <= a_rvalid_d;
      b_rvalid_q <= b_rvalid_d;
    end
  end

endmodule
